io_bus_arbiter: RTL

Two-port arbiter and sequencer placed between the CPU core and `io_bus`. It accepts independent instruction-fetch and data load/store requests, grants the single shared bus port to one of them at a time using round-robin priority, and sequences each transaction through a fixed bus latency. It returns read data with a one-cycle acknowledge pulse, and drives `modwait` so the core stalls while any request is outstanding.

---
 rtl/io_bus_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter sequencing instruction and data port requests onto io_bus
module io_bus_arbiter #(
  parameter int BUS_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [0:8]  instr_addr,
  input  logic [0:63] instr_write_data,
  input  logic        instr_write_enable,
  output logic [0:63] instr_read_data,
  output logic        instr_ack,
  input  logic        data_req,
  input  logic [0:8]  data_addr,
  input  logic [0:63] data_write_data,
  input  logic        data_write_enable,
  output logic [0:63] data_read_data,
  output logic        data_ack,
  output logic [0:8]  bus_addr,
  output logic [0:63] bus_write_data,
  output logic        bus_write_enable,
  input  logic [0:63] bus_read_data,
  output logic        modwait
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last_grant, gnt, bus_wr, pick_data, grant, last, win_we;
  assign pick_data = data_req & (~instr_req | ~last_grant);
  assign grant = (state == IDLE) & (instr_req | data_req);
  assign last = (state == ACCESS) & (cnt == 4'd1);
  assign win_we = pick_data ? data_write_enable : instr_write_enable;
  assign modwait = (instr_req & ~instr_ack) | (data_req & ~data_ack);
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      last_grant <= 1'b0;
      gnt <= 1'b0;
      bus_wr <= 1'b0;
      bus_addr <= '0;
      bus_write_data <= '0;
      bus_write_enable <= 1'b0;
      instr_read_data <= '0;
      data_read_data <= '0;
      instr_ack <= 1'b0;
      data_ack <= 1'b0;
    end else begin
      bus_write_enable <= grant & win_we;
      instr_ack <= last & ~gnt;
      data_ack <= last & gnt;
      if (grant) begin
        cnt <= 4'(BUS_LATENCY);
        last_grant <= pick_data;
        gnt <= pick_data;
        bus_wr <= win_we;
        bus_addr <= pick_data ? data_addr : instr_addr;
        bus_write_data <= pick_data ? data_write_data : instr_write_data;
      end else if (state == ACCESS) cnt <= cnt - 4'd1;
      if (last & ~bus_wr & ~gnt) instr_read_data <= bus_read_data;
      if (last & ~bus_wr & gnt) data_read_data <= bus_read_data;
    end
  end
endmodule
